// File: rtl/muldiv_sequencer.sv
// Multicycle RV32M sequencer: single-cycle multiply, 32-step restoring divide,
// sign fix-up, and early completion for divide-by-zero and signed overflow.
module muldiv_sequencer (
  input  logic        CLK,
  input  logic        RESET,
  input  logic        START,
  input  logic [2:0]  FUNC3,
  input  logic [31:0] OPERAND_A,
  input  logic [31:0] OPERAND_B,
  input  logic        FLUSH,
  output logic        STALL,
  output logic        BUSY,
  output logic        DONE,
  output logic [31:0] RESULT
);

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_MUL  = 3'd1,
    S_DIV  = 3'd2,
    S_FIX  = 3'd3,
    S_DONE = 3'd4
  } state_t;

  state_t      state_q;
  logic [2:0]  func_q;
  logic [31:0] a_q, b_q;
  logic [31:0] quo_q, rem_q, dvsr_q;
  logic [4:0]  cnt_q;
  logic        done_q;
  logic [31:0] result_q;

  // Issue-side decode, evaluated on the raw inputs while IDLE
  logic        in_signed, in_dbz, in_ovf;
  logic [31:0] in_abs_a, in_abs_b, in_special;

  assign in_signed  = ~FUNC3[0];
  assign in_dbz     = (OPERAND_B == 32'd0);
  assign in_ovf     = in_signed && (OPERAND_A == 32'h8000_0000) && (OPERAND_B == 32'hFFFF_FFFF);
  assign in_abs_a   = (in_signed && OPERAND_A[31]) ? (-OPERAND_A) : OPERAND_A;
  assign in_abs_b   = (in_signed && OPERAND_B[31]) ? (-OPERAND_B) : OPERAND_B;
  assign in_special = FUNC3[1] ? (in_dbz ? OPERAND_A : 32'd0)
                               : (in_dbz ? 32'hFFFF_FFFF : 32'h8000_0000);

  logic               a_sx, b_sx;
  logic signed [63:0] a_ext, b_ext, mul_prod;
  logic [31:0]        mul_res;

  assign a_sx     = (func_q == 3'b001 || func_q == 3'b010) && a_q[31];
  assign b_sx     = (func_q == 3'b001) && b_q[31];
  assign a_ext    = {{32{a_sx}}, a_q};
  assign b_ext    = {{32{b_sx}}, b_q};
  assign mul_prod = a_ext * b_ext;
  assign mul_res  = (func_q == 3'b000) ? mul_prod[31:0] : mul_prod[63:32];

  logic [32:0] rem_shift_d, diff_d;
  logic        ge_d;
  logic [31:0] rem_d, quo_d;

  assign rem_shift_d = {rem_q, quo_q[31]};
  assign diff_d      = rem_shift_d - {1'b0, dvsr_q};
  assign ge_d        = ~diff_d[32];
  assign rem_d       = ge_d ? diff_d[31:0] : rem_shift_d[31:0];
  assign quo_d       = {quo_q[30:0], ge_d};

  logic        fx_signed;
  logic [31:0] q_fix, r_fix, fix_res;

  assign fx_signed = ~func_q[0];
  assign q_fix     = (fx_signed && (a_q[31] ^ b_q[31])) ? (-quo_q) : quo_q;
  assign r_fix     = (fx_signed && a_q[31]) ? (-rem_q) : rem_q;
  assign fix_res   = func_q[1] ? r_fix : q_fix;

  always_ff @(posedge CLK) begin
    if (RESET) begin
      state_q  <= S_IDLE;
      func_q   <= 3'd0;
      a_q      <= 32'd0;
      b_q      <= 32'd0;
      quo_q    <= 32'd0;
      rem_q    <= 32'd0;
      dvsr_q   <= 32'd0;
      cnt_q    <= 5'd0;
      done_q   <= 1'b0;
      result_q <= 32'd0;
    end else if (FLUSH) begin
      state_q <= S_IDLE;
      done_q  <= 1'b0;
    end else begin
      case (state_q)
        S_IDLE: begin
          done_q <= 1'b0;
          if (START) begin
            func_q <= FUNC3;
            a_q    <= OPERAND_A;
            b_q    <= OPERAND_B;
            quo_q  <= in_abs_a;
            dvsr_q <= in_abs_b;
            rem_q  <= 32'd0;
            cnt_q  <= 5'd0;
            if (!FUNC3[2]) begin
              state_q <= S_MUL;
            end else if (in_dbz || in_ovf) begin
              result_q <= in_special;
              done_q   <= 1'b1;
              state_q  <= S_DONE;
            end else begin
              state_q <= S_DIV;
            end
          end
        end
        S_MUL: begin
          result_q <= mul_res;
          done_q   <= 1'b1;
          state_q  <= S_DONE;
        end
        S_DIV: begin
          quo_q <= quo_d;
          rem_q <= rem_d;
          cnt_q <= cnt_q + 5'd1;
          if (cnt_q == 5'd31) state_q <= S_FIX;
        end
        S_FIX: begin
          result_q <= fix_res;
          done_q   <= 1'b1;
          state_q  <= S_DONE;
        end
        S_DONE: begin
          done_q  <= 1'b0;
          state_q <= S_IDLE;
        end
        default: begin
          done_q  <= 1'b0;
          state_q <= S_IDLE;
        end
      endcase
    end
  end

  // DONE state releases the stall so the instruction advances with RESULT
  assign STALL  = ~RESET && (((state_q == S_IDLE) && START && !FLUSH) ||
                             (state_q == S_MUL) || (state_q == S_DIV) || (state_q == S_FIX));
  assign BUSY   = ~RESET && (state_q != S_IDLE);
  assign DONE   = done_q;
  assign RESULT = result_q;

endmodule

// File: doc/muldiv_sequencer.md
MULDIV_SEQUENCER -- requirements
Module: muldiv_sequencer

Interface
REQ-001 SHALL have one clock and a reset that is synchronous and active-high.
REQ-002 SHALL provide the following ports, clock and reset first:
- CLK  in  1  clock, all state updates on rising edge.
- RESET  in  1  synchronous active-high reset.
- START  in  1  EX stage holds an M-extension op; sampled only in IDLE.
- FUNC3  in  3  M op: 000 MUL, 001 MULH, 010 MULHSU, 011 MULHU, 100 DIV, 101 DIVU, 110 REM, 111 REMU.
- OPERAND_A  in  32  rs1 value (dividend / multiplicand).
- OPERAND_B  in  32  rs2 value (divisor / multiplier).
- FLUSH  in  1  abort current op (branch/jump flush).
- STALL  out  1  freeze upstream pipeline stages.
- BUSY  out  1  sequencer not in IDLE.
- DONE  out  1  one-cycle pulse; RESULT valid.
- RESULT  out  32  registered result.

Function
REQ-003 SHALL implement states IDLE, MUL, DIV, FIX and DONE.
REQ-004 SHALL latch FUNC3, OPERAND_A and OPERAND_B at the edge ending cycle N when IDLE and START=1 in cycle N.
REQ-005 SHALL ignore START in any state other than IDLE.
REQ-006 SHALL transition IDLE->MUL when FUNC3[2]=0.
REQ-007 SHALL transition IDLE->DIV for a normal divide.
REQ-008 SHALL transition IDLE->DONE directly for divide-by-zero or for signed overflow (DIV/REM with A=0x80000000, B=0xFFFFFFFF).
REQ-009 SHALL, in MUL (one cycle), form the 64-bit product as follows:
- operands sign-extended to 33 bits: A signed for MULH/MULHSU, B signed for MULH only.
- MUL selects product[31:0]; others select product[63:32].
- then go to DONE.
REQ-010 SHALL, in DIV, perform unsigned restoring shift-subtract on the operand magnitudes (absolute values for DIV/REM, raw for DIVU/REMU):
- one quotient bit per cycle, 5-bit iteration counter from 0 to 31.
- exactly 32 cycles, then go to FIX.
REQ-011 SHALL, in FIX (one cycle), apply signs:
- quotient negated when signs of A and B differ.
- remainder takes the sign of A.
- select quotient (DIV/DIVU) or remainder (REM/REMU), then go to DONE.
REQ-012 SHALL produce divide-by-zero results: quotient 0xFFFFFFFF; remainder = OPERAND_A.
REQ-013 SHALL produce overflow results: quotient 0x80000000; remainder 0.
REQ-014 SHALL, in DONE, assert DONE for exactly one cycle, drive RESULT with the new value and return to IDLE unconditionally.
REQ-015 SHALL meet these latencies, measured from START in cycle N:
- multiply: DONE in cycle N+2.
- normal divide: DONE in cycle N+34.
- divide special cases: DONE in cycle N+1.
REQ-016 SHALL compute STALL combinationally as (IDLE and START and not FLUSH) or state in {MUL, DIV, FIX}; STALL SHALL be 0 in DONE so the instruction advances with RESULT.
REQ-017 SHALL drive BUSY=1 in every state except IDLE.
REQ-018 SHALL hold RESULT at the last value delivered by DONE until the next DONE.
REQ-019 SHALL treat FLUSH=1 in any state as follows:
- force IDLE at the next edge; no DONE pulse; RESULT unchanged.
- FLUSH has priority over START.
REQ-020 SHALL discard any partial divide state on abort; a START after a flush begins a fresh operation.

Reset
REQ-021 SHALL, with RESET=1 at an edge, enter IDLE with DONE=0 and RESULT=0, clearing the counter and all operand, quotient and remainder registers.
REQ-022 SHALL drive STALL=0 and BUSY=0 while held in reset.
REQ-023 SHALL let RESET override FLUSH and START, including mid-operation.
REQ-024 SHALL accept START in the first cycle after RESET deasserts.

Verification
REQ-025 SHALL pass these directed scenarios:
- MUL A=7, B=0xFFFFFFFD, START cycle N -> DONE at N+2, RESULT=0xFFFFFFEB; STALL high N..N+1.
- MULHU A=B=0xFFFFFFFF -> RESULT=0xFFFFFFFE; MULH same operands -> RESULT=0x00000000.
- DIV A=0xFFFFFFF9 (-7), B=2 -> DONE at N+34, RESULT=0xFFFFFFFD; REM same operands -> RESULT=0xFFFFFFFF.
- DIVU A=5, B=0 -> DONE at N+1, RESULT=0xFFFFFFFF; REMU A=5, B=0 -> RESULT=5; DIV A=0x80000000, B=0xFFFFFFFF -> RESULT=0x80000000.
- DIV started at N, FLUSH at N+10 -> IDLE, BUSY=0 at N+11, no DONE; new DIVU 100/7 at N+11 -> RESULT=14 at N+45.
- RESET asserted during DIV iteration 20 -> IDLE, RESULT=0, DONE never pulses; START while BUSY never alters the in-flight result.
